// File: rtl/arb_mux_n.sv
// arb_mux_n: N-channel valid/ready arbiter feeding a single registered output
// stage. Arbitration is round-robin (RR=1) or fixed lowest-index priority
// (RR=0). One output register gives exactly one cycle of latency, and a word
// can be consumed and replaced on the same edge for full throughput.
module arb_mux_n #(
    parameter int W  = 4,
    parameter int N  = 4,
    parameter int RR = 1,
    localparam int SW = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        in_valid,
    input  logic [N*W-1:0]      in_data,
    output logic [N-1:0]        in_ready,
    output logic                out_valid,
    output logic [W-1:0]        out_data,
    output logic [SW-1:0]       out_sel,
    input  logic                out_ready
);

    // Channel count at index width plus one bit, so sums of two indices
    // can be compared against it without overflow.
    localparam logic [SW:0] LP_N = (SW+1)'(N);

    // Index increment of one, sized for the modular adder.
    localparam logic [SW:0] LP_ONE = (SW+1)'(1);

    // (base + offset) mod N for base < N and offset < N. One conditional
    // subtract is enough because the raw sum never reaches 2N. This keeps
    // the pointer inside 0..N-1 even when N is not a power of two.
    function automatic logic [SW-1:0] f_mod_add(
        input logic [SW-1:0] base,
        input logic [SW:0]   offset
    );
        logic [SW:0] sum;
        sum = {1'b0, base} + offset;
        if (sum >= LP_N) begin
            sum = sum - LP_N;
        end else begin
            sum = sum;
        end
        return sum[SW-1:0];
    endfunction

    // Circular priority search starting at base. Returns {found, index}.
    // With base fixed at zero this degenerates into lowest-index-wins.
    function automatic logic [SW:0] f_search(
        input logic [N-1:0]  valid,
        input logic [SW-1:0] base
    );
        logic          found;
        logic [SW-1:0] idx;
        logic [SW-1:0] cand;
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = f_mod_add(base, (SW+1)'(k));
            for (int i = 0; i < N; i++) begin
                if (!found && valid[i] && (cand == SW'(i))) begin
                    found = 1'b1;
                    idx   = cand;
                end else begin
                    found = found;
                end
            end
        end
        return {found, idx};
    endfunction

    // Output register and round-robin pointer.
    logic               r_out_valid;
    logic [W-1:0]       r_out_data;
    logic [SW-1:0]      r_out_sel;
    logic [SW-1:0]      r_ptr;

    // Arbitration results.
    logic [SW-1:0]      w_base;
    logic [SW:0]        w_search;
    logic               w_any;
    logic [SW-1:0]      w_gidx;
    logic [N-1:0]       w_grant;
    logic [W-1:0]       w_gdata;
    logic               w_load;
    logic               w_take;

    // Pick the search start: the rotating pointer in round-robin mode,
    // channel 0 in fixed-priority mode.
    always_comb begin
        w_base = '0;
        if (RR != 0) begin
            w_base = r_ptr;
        end else begin
            w_base = '0;
        end
    end

    // Find the winning channel among the requesters.
    always_comb begin
        w_search = f_search(in_valid, w_base);
        w_any    = w_search[SW];
        w_gidx   = w_search[SW-1:0];
    end

    // Decode the winner to one-hot and steer only its data word; the data of
    // every other channel is never referenced, so it cannot leak through.
    always_comb begin
        w_grant = '0;
        w_gdata = '0;
        for (int i = 0; i < N; i++) begin
            if (w_any && (w_gidx == SW'(i))) begin
                w_grant[i] = 1'b1;
                w_gdata    = in_data[i*W +: W];
            end else begin
                w_grant[i] = 1'b0;
            end
        end
    end

    // The register may accept a new word when empty or being drained;
    // in_ready is the grant qualified by that and forced low in reset.
    always_comb begin
        w_load   = (!r_out_valid) || out_ready;
        w_take   = w_load && w_any;
        in_ready = '0;
        if (rst) begin
            in_ready = '0;
        end else if (w_load) begin
            in_ready = w_grant;
        end else begin
            in_ready = '0;
        end
    end

    // Output register: capture the granted word, go empty when loading with
    // no requester, hold everything while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_take) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_gdata;
            r_out_sel   <= w_gidx;
        end else if (w_load) begin
            r_out_valid <= 1'b0;
            r_out_data  <= r_out_data;
            r_out_sel   <= r_out_sel;
        end else begin
            r_out_valid <= r_out_valid;
            r_out_data  <= r_out_data;
            r_out_sel   <= r_out_sel;
        end
    end

    // Round-robin pointer: move just past the channel that was granted,
    // wrapping to 0 after the last channel; untouched without a grant and
    // permanently zero in fixed-priority mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if ((RR != 0) && w_take) begin
            r_ptr <= f_mod_add(w_gidx, LP_ONE);
        end else begin
            r_ptr <= r_ptr;
        end
    end

    // Outputs come straight from the register.
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_arb_mux_n.sv
// Testbench for arb_mux_n: three instances (4-ch round-robin, 4-ch fixed
// priority, 3-ch round-robin) checked against a reference model through a
// scoreboard of expected output-register contents.
module tb_arb_mux_n;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Instance A: W=4 N=4 RR=1
    logic [3:0]  a_iv = 4'b0;
    logic [15:0] a_id = 16'h0;
    logic [3:0]  a_ir;
    logic        a_ov;
    logic [3:0]  a_od;
    logic [1:0]  a_os;
    logic        a_ordy = 1'b1;
    // Instance B: W=4 N=4 RR=0
    logic [3:0]  b_iv = 4'b0;
    logic [15:0] b_id = 16'h0;
    logic [3:0]  b_ir;
    logic        b_ov;
    logic [3:0]  b_od;
    logic [1:0]  b_os;
    logic        b_ordy = 1'b1;
    // Instance C: W=4 N=3 RR=1
    logic [2:0]  c_iv = 3'b0;
    logic [11:0] c_id = 12'h0;
    logic [2:0]  c_ir;
    logic        c_ov;
    logic [3:0]  c_od;
    logic [1:0]  c_os;
    logic        c_ordy = 1'b1;

    arb_mux_n #(.W(4), .N(4), .RR(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_data(a_id), .in_ready(a_ir),
        .out_valid(a_ov), .out_data(a_od), .out_sel(a_os), .out_ready(a_ordy));
    arb_mux_n #(.W(4), .N(4), .RR(0)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_data(b_id), .in_ready(b_ir),
        .out_valid(b_ov), .out_data(b_od), .out_sel(b_os), .out_ready(b_ordy));
    arb_mux_n #(.W(4), .N(3), .RR(1)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_iv), .in_data(c_id), .in_ready(c_ir),
        .out_valid(c_ov), .out_data(c_od), .out_sel(c_os), .out_ready(c_ordy));

    typedef struct packed {
        logic       v;
        logic [3:0] d;
        logic [1:0] s;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state per instance
    logic       m_v[3];
    logic [3:0] m_d[3];
    logic [1:0] m_s[3];
    int         m_ptr[3];
    int         n_of[3]  = '{4, 4, 3};
    int         rr_of[3] = '{1, 0, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic int winner(input logic [3:0] v, input int base, input int n);
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = (base + k) % n;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_v[i] = 1'b0; m_d[i] = 4'h0; m_s[i] = 2'd0; m_ptr[i] = 0;
        end
    endtask

    task automatic drive(input int d, input logic [3:0] v, input logic [15:0] data, input logic ordy);
        case (d)
            0: begin a_iv = v; a_id = data; a_ordy = ordy; end
            1: begin b_iv = v; b_id = data; b_ordy = ordy; end
            2: begin c_iv = v[2:0]; c_id = data[11:0]; c_ordy = ordy; end
            default: ;
        endcase
    endtask

    task automatic sample(input int d, output logic [3:0] rdy, output exp_t o);
        case (d)
            0: begin rdy = a_ir; o.v = a_ov; o.d = a_od; o.s = a_os; end
            1: begin rdy = b_ir; o.v = b_ov; o.d = b_od; o.s = b_os; end
            default: begin rdy = {1'b0, c_ir}; o.v = c_ov; o.d = c_od; o.s = c_os; end
        endcase
    endtask

    // Drive one cycle of stimulus, predict in_ready and the next register
    // contents, check in_ready before the edge and the register after it.
    task automatic step(input int d, input string tag, input logic [3:0] v,
                        input logic [15:0] data, input logic ordy);
        logic [3:0] vm, er, rdy;
        logic       load;
        int         g;
        exp_t       e, got;
        vm   = (n_of[d] == 3) ? {1'b0, v[2:0]} : v;
        drive(d, v, data, ordy);
        load = !m_v[d] || ordy;
        g    = winner(vm, (rr_of[d] != 0) ? m_ptr[d] : 0, n_of[d]);
        er   = (load && g >= 0) ? 4'(1 << g) : 4'b0;
        e.v = m_v[d]; e.d = m_d[d]; e.s = m_s[d];
        if (load) begin
            if (g >= 0) begin
                e.v = 1'b1; e.d = data[g*4 +: 4]; e.s = 2'(g);
                if (rr_of[d] != 0) m_ptr[d] = (g + 1) % n_of[d];
            end else begin
                e.v = 1'b0;
            end
        end
        m_v[d] = e.v; m_d[d] = e.d; m_s[d] = e.s;
        sb.push_back(e);
        #1;
        sample(d, rdy, got);
        chk({tag, "_in_ready"}, 32'(rdy), 32'(er));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        sample(d, rdy, got);
        chk({tag, "_out_valid"}, 32'(got.v), 32'(e.v));
        chk({tag, "_out_data"},  32'(got.d), 32'(e.d));
        chk({tag, "_out_sel"},   32'(got.s), 32'(e.s));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        // Reset state, with requests present: in_ready must still be zero
        a_iv = 4'b1111; a_id = 16'hDCBA;
        #12;
        chk("rst_out_valid", 32'(a_ov), 32'd0);
        chk("rst_out_data",  32'(a_od), 32'd0);
        chk("rst_out_sel",   32'(a_os), 32'd0);
        chk("rst_in_ready",  32'(a_ir), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // All four valid: 0,1,2,3,0 with data a,b,c,d,a
        for (int i = 0; i < 5; i++) step(0, "rr_all", 4'b1111, 16'hDCBA, 1'b1);
        // Channels 1 and 3 only: alternate
        for (int i = 0; i < 4; i++) step(0, "rr_13", 4'b1010, 16'h4321, 1'b1);
        // Back-pressure: word 5 from channel 2 held, then replaced on same edge
        step(0, "bp_load", 4'b0100, 16'h0500, 1'b1);
        for (int i = 0; i < 3; i++) step(0, "bp_hold", 4'b1111, 16'h9876, 1'b0);
        step(0, "bp_swap", 4'b1111, 16'h9876, 1'b1);
        // No requester with load: goes empty, data/sel hold
        step(0, "empty", 4'b0000, 16'hFFFF, 1'b1);
        // Non-granted channel data unknown
        step(0, "xdata", 4'b0001, {{12{1'bx}}, 4'h9}, 1'b1);
        for (int i = 0; i < 40; i++)
            step(0, "rnd_a", 4'($urandom_range(0, 15)), 16'($urandom), $urandom_range(0, 3) != 0);
        step(0, "idle_a", 4'b0000, 16'h0, 1'b1);

        // Fixed priority: channel 1 always beats 2
        for (int i = 0; i < 4; i++) step(1, "fp_0110", 4'b0110, 16'h0A50, 1'b1);
        step(1, "fp_3", 4'b1000, 16'hE000, 1'b1);
        for (int i = 0; i < 30; i++)
            step(1, "rnd_b", 4'($urandom_range(0, 15)), 16'($urandom), $urandom_range(0, 3) != 0);
        step(1, "idle_b", 4'b0000, 16'h0, 1'b1);

        // N=3 round-robin: 0,1,2,0,1 and pointer wraps at 2
        for (int i = 0; i < 5; i++) step(2, "n3_all", 4'b0111, 16'h0CBA, 1'b1);
        for (int i = 0; i < 30; i++)
            step(2, "rnd_c", 4'($urandom_range(0, 7)), 16'($urandom), $urandom_range(0, 3) != 0);
        step(2, "idle_c", 4'b0000, 16'h0, 1'b1);

        // Async reset between edges while a word is held (pointer is 3 here)
        step(0, "ar_load", 4'b0100, 16'h0700, 1'b1);
        step(0, "ar_hold", 4'b1111, 16'h4321, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_out_valid", 32'(a_ov), 32'd0);
        chk("ar_out_data",  32'(a_od), 32'd0);
        chk("ar_out_sel",   32'(a_os), 32'd0);
        chk("ar_in_ready",  32'(a_ir), 32'd0);
        #1;
        rst = 1'b0;
        model_reset();
        step(0, "ar_first", 4'b1111, 16'h4321, 1'b1);
        step(0, "ar_second", 4'b1111, 16'h4321, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_mux_n.md
ARB_MUX_N -- requirements
Module: arb_mux_n

Interface
REQ-001 Parameter W, default 4, data width per channel in bits, W >= 1.
REQ-002 Parameter N, default 4, number of input channels, N >= 2.
REQ-003 Parameter RR, default 1: 1 = round-robin arbitration, 0 = fixed priority with lowest index winning.
REQ-004 Parameter SW, derived as $clog2(N), width of the select output; not overridden by the instantiator.
REQ-005 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 Port in_valid, input, N bits: bit i set means channel i offers data.
REQ-008 Port in_data, input, N*W bits: channel i data in bits [i*W +: W].
REQ-009 Port in_ready, output, N bits: bit i set means channel i data is accepted this cycle.
REQ-010 Port out_valid, output, 1 bit: the output register holds a word.
REQ-011 Port out_data, output, W bits: the registered selected word.
REQ-012 Port out_sel, output, SW bits: index of the channel that supplied out_data.
REQ-013 Port out_ready, input, 1 bit: the consumer accepts the word this cycle.

Function
REQ-014 The block shall contain a single output register holding out_valid, out_data and out_sel; output latency from input acceptance shall be exactly 1 cycle.
REQ-015 load = !out_valid | out_ready; the block shall arbitrate only when load = 1.
REQ-016 in_ready shall be combinational: one-hot at the granted index when load = 1 and any in_valid bit is set, otherwise all zero; it shall never have more than one bit set.
REQ-017 A transfer on channel i occurs when in_valid[i] & in_ready[i]; on that edge the register shall take out_valid = 1, out_data = in_data[i], out_sel = i.
REQ-018 When load = 1 and no in_valid bit is set, the register shall take out_valid = 0; out_data and out_sel shall hold their previous values.
REQ-019 When out_valid = 1 and out_ready = 0, out_valid, out_data and out_sel shall hold stable.
REQ-020 Simultaneous consume and load (out_valid = 1, out_ready = 1, a request present) shall replace the word in the same cycle with no bubble, sustaining 1 word per cycle.
REQ-021 RR = 1: a pointer ptr (SW bits) shall give the highest priority; the search order shall be ptr, ptr+1, ... wrapping modulo N.
REQ-022 RR = 1: after a grant to channel g, ptr shall become (g+1) mod N, including the wrap from g = N-1 to 0; ptr shall be unchanged on cycles without a grant.
REQ-023 RR = 1, N not a power of two: ptr shall never take a value >= N.
REQ-024 RR = 0: the winner shall be the lowest-index set in_valid bit; ptr is unused.
REQ-025 in_data of non-granted channels shall not affect any output, including X values.
REQ-026 Input-side handshake: in_valid may depend on nothing from this block; in_ready may depend on in_valid and out_ready combinationally.

Reset
REQ-027 While rst = 1: out_valid = 0, out_data = 0, out_sel = 0, ptr = 0, and in_ready = 0 regardless of other inputs.
REQ-028 Assertion of rst mid-transfer shall discard the held word immediately, without waiting for a clock edge.
REQ-029 The first grant after rst is released shall follow ptr = 0 priority.

Verification
REQ-030 W=4, N=4, RR=1; after reset, in_valid = 4'b1111, data {d,c,b,a} for channels 3..0, out_ready = 1 -> out_sel sequence 0,1,2,3,0; out_data a,b,c,d,a on consecutive cycles.
REQ-031 RR=1; only channels 1 and 3 valid, out_ready = 1 -> grants alternate 1,3,1,3; in_ready never set for channels 0 or 2.
REQ-032 RR=0; in_valid = 4'b0110 held -> channel 1 wins every cycle; channel 2 is never granted.
REQ-033 Back-pressure: word 'h5 from channel 2 registered, out_ready = 0 for 3 cycles -> out_valid = 1, out_data = 'h5, out_sel = 2 stable; in_ready = 0; with out_ready = 1 the next word loads on the same edge.
REQ-034 N=3 with RR=1, all valid -> sel order 0,1,2,0; ptr never reaches 3.
REQ-035 rst pulsed asynchronously between edges while out_valid = 1 -> out_valid drops to 0 during the pulse; the first grant after release goes to channel 0; in_data of a non-granted channel driven to 'x never propagates to out_data.
